// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction width and fetch FSM encoding.
// Used by fetch_sequencer; the decoder consumes the same opcode map.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_TYPEA = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HALT    = 2'd2,
    ST_ILLEGAL = 2'd3
  } fetch_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_TYPEA, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC select: sequential, branch (4-bit imm) or jump (12-bit offset), jump first.
// Offsets are halfword counts; all sums wrap modulo 2^PC_W. Requires PC_W >= 13.
module next_pc_calc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [11:0]     imm,
  input  logic            jump,
  input  logic            branch,
  input  logic            cond,
  output logic [PC_W-1:0] next_pc
);

  logic signed [PC_W-1:0] jmp_off;
  logic signed [PC_W-1:0] br_off;
  logic        [PC_W-1:0] seq_pc;

  always_comb begin
    seq_pc  = pc + PC_W'(2);
    jmp_off = {{(PC_W-13){imm[11]}}, imm[11:0], 1'b0};
    br_off  = {{(PC_W-5){imm[3]}}, imm[3:0], 1'b0};
    next_pc = seq_pc;
    if (jump) begin
      next_pc = seq_pc + $unsigned(jmp_off);
    end else if (branch && cond) begin
      next_pc = seq_pc + $unsigned(br_off);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer feeding the decoder over a valid/ready handshake.
// Optional macro FETCH_ILLEGAL_TRAP_EN: trap undefined opcodes into a sticky ILLEGAL state.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  input  logic               ctl_branch,
  input  logic               ctl_jump,
  input  logic               br_cond,
`ifdef FETCH_ILLEGAL_TRAP_EN
  output logic               illegal_op,
  output logic [PC_W-1:0]    illegal_pc,
`endif
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    next_pc;
  logic [3:0]         opcode;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic               illegal_op_q, illegal_op_d;
  logic [PC_W-1:0]    illegal_pc_q, illegal_pc_d;
`endif

  assign opcode = id_instr_q[15:12];

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc      (id_pc_q),
    .imm     (id_instr_q[11:0]),
    .jump    (ctl_jump),
    .branch  (ctl_branch),
    .cond    (br_cond),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal_op_d = illegal_op_q;
    illegal_pc_d = illegal_pc_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          id_instr_d = imem_rdata;
          id_pc_d    = pc_q;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (id_ready) begin
          if (opcode == OP_HALT) begin
            state_d = ST_HALT;
`ifdef FETCH_ILLEGAL_TRAP_EN
          end else if (!op_is_legal(opcode)) begin
            state_d      = ST_ILLEGAL;
            illegal_op_d = 1'b1;
            illegal_pc_d = id_pc_q;
`endif
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc_q    <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_op_q <= 1'b0;
      illegal_pc_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_op_q <= illegal_op_d;
      illegal_pc_q <= illegal_pc_d;
`endif
    end
  end

  // Moore outputs, forced inactive while rst is asserted
  assign imem_req  = (state_q == ST_FETCH) && !rst;
  assign id_valid  = (state_q == ST_ISSUE) && !rst;
  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_op_q;
  assign illegal_pc = illegal_pc_q;
  assign halted     = ((state_q == ST_HALT) || (state_q == ST_ILLEGAL)) && !rst;
`else
  assign halted     = (state_q == ST_HALT) && !rst;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table walks a chain of fetches,
// then hand-written sequences cover halt, reset mid-operation and the trap option.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        ctl_branch;
  logic        ctl_jump;
  logic        br_cond;
  logic        halted;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic        illegal_op;
  logic [15:0] illegal_pc;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .ctl_branch (ctl_branch),
    .ctl_jump   (ctl_jump),
    .br_cond    (br_cond),
`ifdef FETCH_ILLEGAL_TRAP_EN
    .illegal_op (illegal_op),
    .illegal_pc (illegal_pc),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    int          ack_dly;
    int          rdy_dly;
    logic        br;
    logic        jmp;
    logic        cond;
    logic [15:0] nxt;
  } vec_t;

  vec_t vecs[11];
  int   nvec;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [15:0] exp_instr;
    logic [15:0] halt_pc;

    vecs[0] = '{16'h0000, 16'h0123, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0002};
    vecs[1] = '{16'h0002, 16'h8000, 3, 4, 1'b0, 1'b0, 1'b0, 16'h0004};
    vecs[2] = '{16'h0004, 16'hC005, 0, 0, 1'b0, 1'b1, 1'b0, 16'h0010};
    vecs[3] = '{16'h0010, 16'h600E, 0, 0, 1'b1, 1'b0, 1'b1, 16'h000E};
    vecs[4] = '{16'h000E, 16'hC000, 1, 0, 1'b0, 1'b1, 1'b0, 16'h0010};
    vecs[5] = '{16'h0010, 16'h600E, 0, 2, 1'b1, 1'b0, 1'b0, 16'h0012};
    vecs[6] = '{16'h0012, 16'hCFF5, 0, 0, 1'b0, 1'b1, 1'b0, 16'hFFFE};
    vecs[7] = '{16'hFFFE, 16'hC001, 0, 0, 1'b1, 1'b1, 1'b1, 16'h0002};
    vecs[8] = '{16'h0002, 16'h5003, 0, 0, 1'b1, 1'b0, 1'b1, 16'h000A};
    vecs[9] = '{16'h000A, 16'h4007, 0, 0, 1'b0, 1'b0, 1'b1, 16'h000C};
`ifdef FETCH_ILLEGAL_TRAP_EN
    nvec    = 10;
    halt_pc = 16'h000C;
`else
    vecs[10] = '{16'h000C, 16'h3ABC, 0, 0, 1'b0, 1'b0, 1'b0, 16'h000E};
    nvec     = 11;
    halt_pc  = 16'h000E;
`endif

    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD; id_ready = 1'b1;
    ctl_branch = 1'b0; ctl_jump = 1'b0; br_cond = 1'b0;
    step();
    step();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", id_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk16("rst_id_instr", id_instr, 16'h0000);
    chk16("rst_id_pc", id_pc, 16'h0000);
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk1("rst_illegal_op", illegal_op, 1'b0);
`endif
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    exp_instr = 16'h0000;

    for (int i = 0; i < nvec; i++) begin
      chk1("fetch_req", imem_req, 1'b1);
      chk16("fetch_addr", imem_addr, vecs[i].pc);
      for (int d = 0; d < vecs[i].ack_dly; d++) begin
        imem_ack = 1'b0; imem_rdata = 16'hDEAD; id_ready = 1'b1;
        step();
        chk1("wait_req", imem_req, 1'b1);
        chk16("wait_addr", imem_addr, vecs[i].pc);
        chk16("wait_instr", id_instr, exp_instr);
        chk1("wait_valid", id_valid, 1'b0);
      end
      imem_ack = 1'b1; imem_rdata = vecs[i].instr; id_ready = 1'b0;
      step();
      imem_ack = 1'b0; imem_rdata = 16'hDEAD;
      exp_instr = vecs[i].instr;
      chk1("issue_valid", id_valid, 1'b1);
      chk16("issue_instr", id_instr, vecs[i].instr);
      chk16("issue_pc", id_pc, vecs[i].pc);
      chk1("issue_req", imem_req, 1'b0);
      for (int d = 0; d < vecs[i].rdy_dly; d++) begin
        imem_ack = 1'b1; imem_rdata = 16'hBEEF; id_ready = 1'b0;
        step();
        chk1("stall_valid", id_valid, 1'b1);
        chk16("stall_instr", id_instr, vecs[i].instr);
        chk16("stall_pc", id_pc, vecs[i].pc);
        chk1("stall_req", imem_req, 1'b0);
      end
      imem_ack = 1'b0;
      id_ready = 1'b1; ctl_branch = vecs[i].br; ctl_jump = vecs[i].jmp; br_cond = vecs[i].cond;
      step();
      id_ready = 1'b0; ctl_branch = 1'b0; ctl_jump = 1'b0; br_cond = 1'b0;
      chk1("xfer_valid", id_valid, 1'b0);
      chk1("xfer_req", imem_req, 1'b1);
      chk16("next_pc", imem_addr, vecs[i].nxt);
    end

    // Halt: sticky until reset, spurious acks and ready ignored
    chk16("halt_addr", imem_addr, halt_pc);
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    step();
    imem_ack = 1'b0;
    chk16("halt_instr", id_instr, 16'hF000);
    id_ready = 1'b1;
    step();
    chk1("halted", halted, 1'b1);
    for (int c = 0; c < 20; c++) begin
      imem_ack = 1'b1; imem_rdata = 16'h0123; id_ready = 1'b1;
      step();
      chk1("halt_no_req", imem_req, 1'b0);
      chk1("halt_no_valid", id_valid, 1'b0);
      chk1("halt_stays", halted, 1'b1);
    end
    rst = 1'b1;
    step();
    chk1("halt_rst_req", imem_req, 1'b0);
    chk1("halt_rst_halted", halted, 1'b0);
    rst = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    #1;
    chk1("resume_req", imem_req, 1'b1);
    chk16("resume_addr", imem_addr, 16'h0000);
    chk16("resume_instr", id_instr, 16'h0000);

    // Reset while holding an instruction in ISSUE
    imem_ack = 1'b1; imem_rdata = 16'h0123;
    step();
    imem_ack = 1'b0;
    chk1("mid_issue_valid", id_valid, 1'b1);
    rst = 1'b1;
    step();
    chk1("mid_rst_valid", id_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("mid_after_valid", id_valid, 1'b0);
    chk1("mid_after_req", imem_req, 1'b1);
    chk16("mid_after_instr", id_instr, 16'h0000);

    // Reset during an outstanding fetch at a nonzero pc, with ack in the rst cycle
    imem_ack = 1'b1; imem_rdata = 16'h0123;
    step();
    imem_ack = 1'b0; id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk16("pre_rst_addr", imem_addr, 16'h0002);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h8888;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    chk16("fetch_rst_addr", imem_addr, 16'h0000);
    chk16("fetch_rst_instr", id_instr, 16'h0000);
    chk1("fetch_rst_valid", id_valid, 1'b0);

`ifdef FETCH_ILLEGAL_TRAP_EN
    imem_ack = 1'b1; imem_rdata = 16'hC001;
    step();
    imem_ack = 1'b0; id_ready = 1'b1; ctl_jump = 1'b1;
    step();
    id_ready = 1'b0; ctl_jump = 1'b0;
    chk16("ill_addr", imem_addr, 16'h0004);
    imem_ack = 1'b1; imem_rdata = 16'h3000;
    step();
    imem_ack = 1'b0; id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk1("ill_op", illegal_op, 1'b1);
    chk16("ill_pc", illegal_pc, 16'h0004);
    chk1("ill_halted", halted, 1'b1);
    chk1("ill_no_req", imem_req, 1'b0);
    step();
    chk1("ill_sticky", illegal_op, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch and PC sequencing block; the producer side of the 4-bit opcode interface that the main control decoder consumes.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and presents them to decode with a valid/ready handshake.
- Takes the decoder's Branch/Jump outputs plus the comparator result at transfer time and selects the next PC.
- Stops permanently on Halt (opcode 4'b1111) until reset.

Parameters:
- PC_W, 16, PC and imem address width in bits; byte-addressed, instructions 2 bytes.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  PC_W  fetch address (= pc); stable while imem_req high.
- imem_ack  in  1  read data valid this cycle; ignored unless imem_req high.
- imem_rdata  in  16  instruction word.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts; transfer = id_valid & id_ready.
- id_instr  out  16  held instruction; opcode = id_instr[15:12], drives the decoder.
- id_pc  out  PC_W  address of id_instr.
- ctl_branch  in  1  decoder Branch for id_instr; combinational, sampled only at transfer.
- ctl_jump  in  1  decoder Jump for id_instr; sampled only at transfer.
- br_cond  in  1  comparator result for blt/bgt/beq; sampled only at transfer.
- halted  out  1  high in HALT (and ILLEGAL when enabled).

Behaviour:
- Reset values:
  - state = FETCH, pc = RESET_PC.
  - id_instr = 0, id_pc = 0.
  - imem_req = 0 during the reset cycle (outputs are gated by rst).
  - id_valid = 0, halted = 0.
- States: FETCH, ISSUE, HALT (ILLEGAL optional).
  - Outputs are Moore decoded from state: imem_req = (state==FETCH), id_valid = (state==ISSUE).
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: latch id_instr <= imem_rdata and id_pc <= pc, then go to ISSUE.
  - Without imem_ack, stay in FETCH with address unchanged.
- ISSUE:
  - id_valid = 1; id_instr and id_pc stay stable while id_ready = 0.
  - On transfer:
    - If opcode == 4'b1111, go to HALT; pc is not updated.
    - Otherwise compute next_pc and go to FETCH.
- next_pc, all arithmetic modulo 2^PC_W (wraps silently):
  - ctl_jump = 1: id_pc + 2 + (sext(id_instr[11:0]) << 1).
  - else ctl_branch = 1 and br_cond = 1: id_pc + 2 + (sext(id_instr[3:0]) << 1).
  - else: id_pc + 2.
  - ctl_jump has priority if both ctl_jump and ctl_branch are asserted.
- HALT: no requests; id_valid = 0, halted = 1. Only rst exits.
- Latency:
  - First imem_req is in the cycle after rst deasserts.
  - With ack in the same cycle as req and id_ready held high, throughput is one instruction per 2 cycles.
- Reset mid-operation:
  - An outstanding request is abandoned; an imem_ack in the rst cycle is ignored.
  - A held instruction is discarded; pc returns to RESET_PC.
- Spurious imem_ack outside FETCH is ignored. id_ready outside ISSUE is ignored.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - Legal opcodes are 0000, 1000, 1011, 0100, 0101, 0110, 1100, 1111.
  - Transfer of any other opcode goes to ILLEGAL: behaves like HALT, plus output illegal_op (1 bit, reset 0) = 1 and output illegal_pc = id_pc of the offending instruction.
- Undefined:
  - Illegal opcodes are sequenced as pc+2 (the decoder's default yields no branch/jump).
  - Ports illegal_op and illegal_pc do not exist.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams OP_TYPEA = 4'b0000, OP_LW = 4'b1000, OP_SW = 4'b1011, OP_BLT = 4'b0100, OP_BGT = 4'b0101, OP_BEQ = 4'b0110, OP_JMP = 4'b1100, OP_HALT = 4'b1111.
  - fetch state encoding.
  - INSTR_W = 16.
- One sub-module, next_pc_calc: combinational target/offset adder and priority select, reused by a later branch-predict block.

Test Plan:
- Reset, then imem returns 16'h0123 at addr 0 with same-cycle ack, id_ready = 1 -> first req at cycle 1; id_valid with id_pc = 0; next request to addr 2.
- imem_ack delayed 3 cycles -> imem_req and imem_addr stable all 3 cycles; id_instr latched only on the ack cycle.
- id_ready low 4 cycles in ISSUE -> id_instr and id_pc unchanged; no new imem_req until transfer.
- beq at pc 16'h0010, imm 4'b1110, ctl_branch = 1:
  - br_cond = 1 -> next fetch at 16'h000E.
  - br_cond = 0 -> next fetch at 16'h0012.
- jmp at 16'hFFFE with offset 12'h001, ctl_jump = 1 and ctl_branch = 1 -> next fetch at 16'h0002 (wrap, jump priority).
- Halt 16'hF000 transfers -> halted = 1, no further imem_req for 20 cycles; rst -> fetch resumes at RESET_PC. With FETCH_ILLEGAL_TRAP_EN, opcode 4'b0011 at 16'h0004 -> illegal_op = 1, illegal_pc = 16'h0004.
